// File: rtl/mac_out_accumulator.sv
// rtl/mac_out_accumulator.sv - accumulates tree sums per pixel, scales, saturates and queues results
//
// Ports:
//   clk            clock
//   arst_n_in      asynchronous active-low reset
//   sum_valid_in   tree sum beat valid
//   sum_in         signed tree sum (ACCUMULATOR_WIDTH)
//   sum_first_in   beat starts a new pixel group (accumulator restarts from 0)
//   sum_last_in    beat closes the group and pushes a result
//   sum_ready_out  beat can be accepted (output FIFO not full)
//   out_valid      output FIFO head valid
//   out_ready      consumer takes the head
//   out            signed output pixel (FIFO head, 0 while empty)
//   sat_count      number of clamped results pushed, sticky at 0xFFFF
//
// Optional build macro MAC_OUT_RELU_EN: negative scaled sums become 0 before
// saturation; that clamp is not counted in sat_count.

module mac_out_accumulator #(
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int OUTPUT_SCALE      = 0,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                clk,
  input  logic                                arst_n_in,
  input  logic                                sum_valid_in,
  input  logic signed [ACCUMULATOR_WIDTH-1:0] sum_in,
  input  logic                                sum_first_in,
  input  logic                                sum_last_in,
  output logic                                sum_ready_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUTPUT_WIDTH-1:0]      out,
  output logic [15:0]                         sat_count
);

  localparam int AW    = ACCUMULATOR_WIDTH;
  localparam int OW    = OUTPUT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Output range limits sign-extended to the accumulator width so the clamp
  // compares are full-width signed compares.
  localparam logic signed [AW-1:0] MAX_V = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] total;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] clip_in;
  logic signed [OW-1:0] result;
  logic                 clamped;
  logic                 accept;
  logic                 push;
  logic                 pop;

  logic signed [OW-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  // Ready depends only on the registered count, never on out_ready.
  assign sum_ready_out = (count != FULL_CNT);
  assign out_valid     = (count != '0);
  assign out           = out_valid ? mem[rd_ptr] : '0;

  assign accept = sum_valid_in && sum_ready_out;
  assign push   = accept && sum_last_in;
  assign pop    = out_valid && out_ready;

  // Wrapping add; a first beat ignores whatever is left in acc.
  assign total   = (sum_first_in ? {AW{1'b0}} : acc) + sum_in;
  assign shifted = total >>> OUTPUT_SCALE;

`ifdef MAC_OUT_RELU_EN
  assign clip_in = shifted[AW-1] ? {AW{1'b0}} : shifted;
`else
  assign clip_in = shifted;
`endif

  always_comb begin
    result  = clip_in[OW-1:0];
    clamped = 1'b0;
    if (clip_in > MAX_V) begin
      result  = MAX_V[OW-1:0];
      clamped = 1'b1;
    end else if (clip_in < MIN_V) begin
      result  = MIN_V[OW-1:0];
      clamped = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      acc       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sat_count <= '0;
    end else begin
      if (accept) begin
        acc <= sum_last_in ? {AW{1'b0}} : total;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && clamped && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

  // Payload storage needs no reset: out is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

endmodule
